// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage valid/ready register pipeline, WIDTH bits per stage.
//
// Each stage holds a valid bit and a data word. The ready chain is combinational
// and collapses bubbles: a stage can load when it is empty, or when some stage
// downstream of it (or the consumer) can take a word this cycle. Data registers
// are clock-enabled only when valid data actually moves in, so bubbles never
// toggle them. flush drops all in-flight words at the edge and takes priority
// over every transfer.
//
// Optional feature: define DFF_PIPE_PARITY_EN to carry an even-parity bit next
// to each data word and expose par_err. Without it the pipe has no parity
// storage and no par_err port.
module dff_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
`ifdef DFF_PIPE_PARITY_EN
  output logic                         par_err,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] v_src;
  logic [DEPTH-1:0] ld;
  logic [WIDTH-1:0] d_q   [DEPTH];
  logic [WIDTH-1:0] d_src [DEPTH];

  // Ready chain: stage k may advance if any stage from k to the tail is empty
  // or the consumer accepts the tail word this cycle.
  always_comb begin
    logic acc;
    acc = out_ready;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      acc    = acc | ~v_q[k];
      rdy[k] = acc;
    end
  end

  // Source of each stage: the upstream port for stage 0, else the previous stage.
  always_comb begin
    v_src[0] = in_valid;
    d_src[0] = in_data;
    for (int k = 1; k < int'(DEPTH); k++) begin
      v_src[k] = v_q[k-1];
      d_src[k] = d_q[k-1];
    end
  end

  // Next valid state and per-stage data load enables; flush wins over transfers.
  always_comb begin
    for (int k = 0; k < int'(DEPTH); k++) begin
      ld[k]  = rdy[k] & v_src[k] & ~flush;
      v_d[k] = flush ? 1'b0 : (rdy[k] ? v_src[k] : v_q[k]);
    end
  end

  // Valid bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

  // Data registers, enabled only when a valid word moves into the stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        d_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        if (ld[k]) begin
          d_q[k] <= d_src[k];
        end
      end
    end
  end

`ifdef DFF_PIPE_PARITY_EN
  logic [DEPTH-1:0] par_q;
  logic [DEPTH-1:0] par_src;

  // Parity is generated once at the input and then travels with its word.
  always_comb begin
    par_src[0] = ^in_data;
    for (int k = 1; k < int'(DEPTH); k++) begin
      par_src[k] = par_q[k-1];
    end
  end

  // Parity bits share the data load enables.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q <= '0;
    end else begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        if (ld[k]) begin
          par_q[k] <= par_src[k];
        end
      end
    end
  end

  // Flag a tail word whose recomputed parity disagrees with the carried bit.
  always_comb begin
    par_err = v_q[DEPTH-1] & ((^d_q[DEPTH-1]) ^ par_q[DEPTH-1]);
  end
`endif

  // Occupancy is the population count of the valid bits.
  always_comb begin
    occupancy = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      occupancy = occupancy + OccW'(v_q[k]);
    end
  end

  // Handshake and tail outputs.
  always_comb begin
    in_ready  = rdy[0];
    out_valid = v_q[DEPTH-1];
    out_data  = d_q[DEPTH-1];
  end

endmodule

// File: tb/tb_dff_pipe.sv
// Directed self-checking bench for dff_pipe (WIDTH=8, DEPTH=4).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_dff_pipe;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [2:0]   occupancy;
`ifdef DFF_PIPE_PARITY_EN
  logic         par_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int peak;

  dff_pipe #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
`ifdef DFF_PIPE_PARITY_EN
    .par_err  (par_err),
`endif
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_occ", occupancy, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Three words into an empty pipe: first output 4 cycles after acceptance
    out_ready = 1'b1;
    peak = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = (i < 3);
      in_data  = 8'((i + 1) * 17);
      #1;
      if (i < 3) check("lat_in_ready", in_ready, 1);
      check("lat_out_valid", out_valid, (i >= 4 && i <= 6));
      if (i >= 4 && i <= 6) check("lat_out_data", out_data, 8'((i - 3) * 17));
      check("lat_occ", occupancy, (i <= 3) ? i : 7 - i);
`ifdef DFF_PIPE_PARITY_EN
      check("lat_par_err", par_err, 0);
`endif
      if (int'(occupancy) > peak) peak = int'(occupancy);
      @(negedge clk);
    end
    check("lat_peak_occ", peak, 3);

    // Fill with a stalled consumer, reject the fifth word, then drain
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hA0 + i);
      #1;
      check("fill_in_ready", in_ready, 1);
      @(negedge clk);
    end
    in_data = 8'hA4;
    #1;
    check("full_occ", occupancy, 4);
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    check("full_out_data", out_data, 8'hA0);
    @(negedge clk);
    #1;
    check("stall_occ", occupancy, 4);
    check("stall_out_data", out_data, 8'hA0);
    out_ready = 1'b1;
    #1;
    check("unstall_in_ready", in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) in_valid = 1'b0;
      #1;
      check("drain_out_valid", out_valid, 1);
      check("drain_out_data", out_data, 8'(8'hA0 + i));
      @(negedge clk);
    end
    #1;
    check("drain_empty_valid", out_valid, 0);
    check("drain_empty_occ", occupancy, 0);

    // Full pipe streaming: simultaneous in/out keeps occupancy at DEPTH
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hB0 + i);
      #1;
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hC0 + i);
      #1;
      check("stream_occ", occupancy, 4);
      check("stream_in_ready", in_ready, 1);
      check("stream_out_valid", out_valid, 1);
      check("stream_out_data", out_data, (i < 4) ? 8'(8'hB0 + i) : 8'(8'hC0 + i - 4));
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stream_tail_data", out_data, 8'(8'hC6 + i));
      @(negedge clk);
    end
    #1;
    check("stream_end_occ", occupancy, 0);

    // Flush with three words in flight; the word offered alongside is dropped
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hD0 + i);
      #1;
      @(negedge clk);
    end
    #1;
    check("pre_flush_occ", occupancy, 3);
    flush    = 1'b1;
    in_data  = 8'h55;
    #1;
    check("flush_in_ready", in_ready, 1);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post_flush_occ", occupancy, 0);
    check("post_flush_valid", out_valid, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("flush_no_55", out_valid, 0);
      @(negedge clk);
    end

    // Flush of a full pipe leaves the tail visible until the edge
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h90 + i);
      #1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    flush    = 1'b1;
    #1;
    check("flush_full_valid", out_valid, 1);
    check("flush_full_data", out_data, 8'h90);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_full_occ", occupancy, 0);
    @(negedge clk);

    // Asynchronous reset mid-burst, then a fresh word emerges first
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hE0 + i);
      #1;
      if (i == 4) begin
        check("preRst_out_valid", out_valid, 1);
        check("preRst_out_data", out_data, 8'hE0);
      end else begin
        @(negedge clk);
      end
    end
    #1;
    rst = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_occ", occupancy, 0);
    check("arst_in_ready", in_ready, 1);
    @(negedge clk);
    #1;
    check("rst_edge_no_xfer", occupancy, 0);
    rst      = 1'b1;
    in_data  = 8'h77;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check("post_rst_out_valid", out_valid, (i == 4));
      if (i == 4) check("post_rst_out_data", out_data, 8'h77);
      @(negedge clk);
    end
    #1;
    check("post_rst_empty", occupancy, 0);

`ifdef DFF_PIPE_PARITY_EN
    // Corrupt the tail parity bit of a stalled full pipe
    begin
      logic [D-1:0] pq;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
        in_valid = 1'b1;
        in_data  = 8'(8'h31 + i);
        #1;
        @(negedge clk);
      end
      in_valid = 1'b0;
      #1;
      check("par_clean", par_err, 0);
      pq = dut.par_q;
      force dut.par_q = pq ^ 4'b1000;
      #1;
      check("par_err_forced", par_err, 1);
      release dut.par_q;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("par_err_cleared", par_err, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data width per stage in bits (1..64).
REQ-002 Parameter DEPTH, default 4, number of register stages (1..16).
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-low.
REQ-005 Port flush  input  1  synchronous clear of all in-flight data.
REQ-006 Port in_valid  input  1  upstream data valid.
REQ-007 Port in_data  input  WIDTH  upstream data.
REQ-008 Port in_ready  output  1  pipe accepts in_data this cycle.
REQ-009 Port out_valid  output  1  last stage holds valid data.
REQ-010 Port out_data  output  WIDTH  last-stage data.
REQ-011 Port out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 Port occupancy  output  $clog2(DEPTH+1)  count of valid stages.

Function
REQ-013 Each stage k (0..DEPTH-1) SHALL hold one valid bit v[k] and one WIDTH-bit data register d[k]. Stage 0 is the input stage; stage DEPTH-1 drives out_valid/out_data.
REQ-014 Stage ready r[k] = ~v[k] | r[k+1], with r[DEPTH] = out_ready; in_ready SHALL equal r[0] (combinational, bubble-collapsing).
REQ-015 Transfers SHALL occur only on valid & ready. The input transfer is in_valid & in_ready; the output transfer is out_valid & out_ready.
REQ-016 When r[k] = 1, stage k SHALL load v/d from stage k-1 (stage 0 loads from in_valid/in_data). When r[k] = 0, stage k holds v[k] and d[k].
REQ-017 Latency into an empty pipe with out_ready held high SHALL be exactly DEPTH cycles from the input transfer to out_valid. Sustained throughput SHALL be one word per cycle.
REQ-018 Data order SHALL be strict FIFO. No word may be dropped, duplicated or reordered under any out_ready pattern.
REQ-019 A stalled stage (v = 1, r = 0) SHALL keep d stable. out_data SHALL remain stable while out_valid & ~out_ready.
REQ-020 occupancy SHALL equal the popcount of v[] after each edge. Range 0..DEPTH.
REQ-021 Full pipe (occupancy = DEPTH) with out_ready = 0 SHALL give in_ready = 0. The same full pipe with out_ready = 1 SHALL give in_ready = 1, and a simultaneous input and output transfer SHALL leave occupancy unchanged.
REQ-022 Empty pipe SHALL give out_valid = 0. out_data is don't-care but SHALL retain its last value (no X after reset).
REQ-023 flush = 1 SHALL clear every v[k] at the edge and force occupancy to 0. in_valid in that cycle SHALL be discarded; flush has priority over all transfers. in_ready SHALL still follow REQ-014.
REQ-024 While flush is high, out_valid SHALL be unaffected until the edge; the word presented in that cycle counts as delivered only if out_ready = 1.
REQ-025 d[k] SHALL update only when stage k loads valid data. Bubbles SHALL NOT clock-enable data registers.

Reset
REQ-026 rst low SHALL immediately clear all v[k], all d[k] to 0 and occupancy to 0. Outputs: out_valid = 0, out_data = 0, occupancy = 0, in_ready = 1.
REQ-027 Reset asserted mid-stream SHALL discard all in-flight words. The first accepted word after rst deassertion SHALL be the first word observed at the output.
REQ-028 Deassertion SHALL be honoured on the next rising clk. No transfer SHALL occur on the edge coincident with rst low.

Configuration
REQ-029 Macro DFF_PIPE_PARITY_EN defined: each stage SHALL carry an even-parity bit computed from in_data at stage 0 and propagated with d[k]. An added output par_err (1 bit) SHALL be asserted whenever out_valid = 1 and the parity of out_data mismatches the carried bit; it resets to 0.
REQ-030 Macro undefined: no parity storage and no par_err port; behaviour is otherwise identical.

Verification
REQ-031 Reset then DEPTH=4, WIDTH=8, out_ready=1, in 0x11,0x22,0x33 on consecutive cycles -> out_valid rises 4 cycles after 0x11 accepted; 0x11,0x22,0x33 in order; occupancy peaks at 3.
REQ-032 out_ready=0, push 0xA0..0xA3 -> occupancy=4, in_ready=0, extra 0xA4 not accepted. Then out_ready=1 with in_valid held -> 0xA0..0xA4 in order, one per cycle.
REQ-033 Full pipe, out_ready=1, in_valid=1 for 10 cycles -> occupancy stays 4 and 10 words delivered in order.
REQ-034 Pipe holding 3 words, flush=1 with in_valid=1 (0x55) -> next cycle occupancy=0, out_valid=0; 0x55 never appears at output.
REQ-035 rst pulled low asynchronously mid-burst between edges -> out_valid=0 and out_data=0 before the next edge. After release, new word 0x77 emerges first after 4 cycles.
REQ-036 DFF_PIPE_PARITY_EN defined, force-invert carried parity of stage 3 -> par_err=1 while that word is valid; par_err=0 for all clean traffic.
